// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential 32x32 multiplier.
// State encodings, iteration count and adder operand bundle.
package mul_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABS_A  = 3'd1;
  localparam logic [2:0] S_ABS_B  = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_FIX_LO = 3'd4;
  localparam logic [2:0] S_FIX_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int unsigned MUL_ITERS = 32;
  localparam logic [4:0]  CNT_LAST  = 5'(MUL_ITERS - 1);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
  } add_op_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bundle of the sequential multiplier.
// master issues operands, slave returns the product.
interface mul_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_seq_add_32.sv
// 32-bit adder with carry-in; cout is the 33rd sum bit.
// Shared by every arithmetic step of mul_seq.
module add_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ad_o_sb,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  assign {cout_o, sum_o} =
    {1'b0, a_i} + {1'b0, b_i} + {32'h0, ad_o_sb};
endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 multiplier: abs, 32-step shift-add, sign fix.
// Fixed 37-cycle latency for MULT and MULTU.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mul_seq_if.slave  bus
);

  logic [2:0]  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        neg_q, neg_d;
  logic        carry_q, carry_d;
  logic [4:0]  cnt_q, cnt_d;

  add_op_t     op;
  logic [31:0] sum;
  logic        cout;

  logic st_idle, st_abs_a, st_abs_b, st_mul;
  logic st_fix_lo, st_fix_hi, st_done;

  assign st_idle   = (state_q == S_IDLE);
  assign st_abs_a  = (state_q == S_ABS_A);
  assign st_abs_b  = (state_q == S_ABS_B);
  assign st_mul    = (state_q == S_MUL);
  assign st_fix_lo = (state_q == S_FIX_LO);
  assign st_fix_hi = (state_q == S_FIX_HI);
  assign st_done   = (state_q == S_DONE);

  add_32 u_add (
    .a_i     (op.x),
    .b_i     (op.y),
    .ad_o_sb (op.cin),
    .sum_o   (sum),
    .cout_o  (cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op      = '0;
    unique case (1'b1)
      st_idle, st_done: begin
        state_d = S_IDLE;
        if (bus.start) begin
          mcand_d = bus.a;
          mplr_d  = bus.b;
          sgn_d   = bus.is_signed;
          neg_d   = bus.is_signed
                  & (bus.a[31] ^ bus.b[31]);
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ABS_A;
        end
      end
      st_abs_a: begin
        op = '{x: ~mcand_q, y: 32'h0, cin: 1'b1};
        if (sgn_q & mcand_q[31])
          mcand_d = sum;
        state_d = S_ABS_B;
      end
      st_abs_b: begin
        op = '{x: ~mplr_q, y: 32'h0, cin: 1'b1};
        if (sgn_q & mplr_q[31])
          mplr_d = sum;
        state_d = S_MUL;
      end
      st_mul: begin
        // Zero addend when the multiplier bit is clear.
        op = '{x: acc_q,
               y: mplr_q[0] ? mcand_q : 32'h0,
               cin: 1'b0};
        acc_d   = {cout, sum[31:1]};
        mplr_d  = {sum[0], mplr_q[31:1]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST)
          state_d = S_FIX_LO;
      end
      st_fix_lo: begin
        op = '{x: ~mplr_q, y: 32'h0, cin: 1'b1};
        if (neg_q) begin
          mplr_d  = sum;
          carry_d = cout;
        end
        state_d = S_FIX_HI;
      end
      st_fix_hi: begin
        op = '{x: ~acc_q, y: 32'h0, cin: carry_q};
        if (neg_q)
          acc_d = sum;
        hi_d    = neg_q ? sum : acc_q;
        lo_d    = mplr_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = ~(st_idle | st_done);
  assign bus.done = st_done;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq against a plain 64-bit product model.
// Checks cycle-accurate busy/done, result hold, handshake and reset.
module tb_mul_seq;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [63:0] last;

  mul_seq_if bus ();

  mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, timeout reached");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [65:0] obs,
    input logic [65:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed busy/done/hi/lo=%h required=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] outs();
    return {bus.busy, bus.done, bus.hi, bus.lo};
  endfunction

  task automatic launch(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom);
  endtask

  // Entered at the negedge of cycle 1; leaves at the negedge of cycle 37.
  task automatic track(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input int          pulse_at
  );
    logic [63:0] exp;
    exp = ref_mul(a, b, s);
    for (int c = 1; c <= 36; c++) begin
      chk({tag, "_busy"}, outs(), {1'b1, 1'b0, last});
      if (c == pulse_at) begin
        bus.start     = 1'b1;
        bus.a         = ~a;
        bus.b         = b ^ 32'h5a5a_1234;
        bus.is_signed = ~s;
      end
      if (c == pulse_at + 1)
        bus.start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done"}, outs(), {1'b0, 1'b1, exp});
    last = exp;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, outs(), {1'b0, 1'b0, last});
  endtask

  task automatic op(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    launch(a, b, s);
    track(tag, a, b, s, 0);
    idle_chk({tag, "_idle"});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner = '{32'h0, 32'h1, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0)
      return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    vectors       = 0;
    miscompares   = 0;
    last          = '0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (3) @(negedge clk);
    chk("reset", outs(), '0);
    rst = 1'b0;
    idle_chk("idle_after_reset");

    op("u3x5",   32'd3,          32'd5,          1'b0);
    op("umax",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    op("sm1x7",  32'hFFFF_FFFF,  32'd7,          1'b1);
    op("smin2",  32'h8000_0000,  32'h8000_0000,  1'b1);
    op("smin_n", 32'h8000_0000,  32'h0000_0003,  1'b1);
    op("szero",  32'h0,          32'hFFFF_FFFE,  1'b1);

    // Start pulsed mid-operation must be ignored.
    launch(32'h1234_5678, 32'h9abc_def0, 1'b1);
    track("ign5", 32'h1234_5678, 32'h9abc_def0, 1'b1, 5);

    // Start held in the done cycle chains the next op.
    launch(32'hDEAD_BEEF, 32'h0000_1001, 1'b0);
    track("chain", 32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 0);
    idle_chk("chain_idle");

    // Reset in cycle 10 abandons the op with no done pulse.
    launch(32'h0F0F_0F0F, 32'h3333_3333, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      chk("pre_rst_busy", outs(), {1'b1, 1'b0, last});
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    last = '0;
    chk("rst_midop", outs(), '0);
    launch(32'h8000_0000, 32'd2, 1'b0);
    track("post_rst", 32'h8000_0000, 32'd2, 1'b0, 0);
    idle_chk("post_rst_idle");

    for (int i = 0; i < 24; i++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom);
      launch(ra, rb, rs);
      track("rand", ra, rb, rs, ($urandom_range(3) == 0) ? 
            int'($urandom_range(35, 1)) : 0);
      if ($urandom_range(1) == 0) begin
        ra = pick();
        rb = pick();
        rs = 1'($urandom);
        launch(ra, rb, rs);
        track("rand_chain", ra, rb, rs, 0);
      end
      idle_chk("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-005 is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-006 a  input  32  multiplicand; sampled with start.
REQ-007 b  input  32  multiplier; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; hi/lo are valid.
REQ-010 hi  output  32  upper product word.
REQ-011 lo  output  32  lower product word.

Function
REQ-012 The FSM SHALL have these states: IDLE, ABS_A, ABS_B, MUL, FIX_LO, FIX_HI, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch a, b and is_signed, latch neg = is_signed & (a[31]^b[31]), and go to ABS_A.
REQ-014 In DONE with start=0 the FSM SHALL go to IDLE.
REQ-015 start SHALL be ignored in every other state; latched operands stay unchanged.
REQ-016 ABS_A SHALL replace the latched a with its two's-complement negation only if is_signed & a[31]; otherwise a passes through. The state lasts 1 cycle.
REQ-017 ABS_B SHALL do the same for b and last 1 cycle.
REQ-018 MUL SHALL run exactly 32 cycles (5-bit counter) as radix-2 shift-add on a 65-bit register {carry, acc[31:0], mplr[31:0]}, with acc=0 at entry.
  - Each cycle: if mplr[0]=1, {carry,acc} = acc + mcand (33-bit); otherwise {carry,acc} = {0,acc}.
  - Then the whole register shifts right by 1.
REQ-019 FIX_LO SHALL compute lo' = ~lo + 1 and capture its carry-out, only if neg=1; otherwise it is a pass-through. The state lasts 1 cycle.
REQ-020 FIX_HI SHALL compute hi' = ~hi + carry_from_FIX_LO, only if neg=1; otherwise it is a pass-through. The state lasts 1 cycle.
REQ-021 Latency SHALL be fixed regardless of operands or sign: start sampled at edge 0; busy=1 during cycles 1..36; done=1 during cycle 37 only.
REQ-022 hi/lo SHALL be updated only on entry to DONE and held until the next DONE entry. They do not change while busy.
REQ-023 The result SHALL equal the exact 64-bit product, unsigned or signed per is_signed. This includes a or b = 0x80000000 with is_signed=1.
REQ-024 busy and done SHALL never be high in the same cycle.
REQ-025 A start accepted in DONE SHALL give busy=1 in the next cycle (back-to-back operation, no idle gap).

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear all internal registers, at the next edge, from any state.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse. A start in the first cycle after rst deasserts SHALL be accepted normally.

Structure
REQ-028 State encodings and the MUL iteration count (32) SHALL live in the shared ALU definitions file, not locally.
REQ-029 Exactly one add_32 instance SHALL be used, shared by ABS_A, ABS_B, MUL, FIX_LO and FIX_HI through operand muxes.
  - Negation: a=~x, b=0, ad_o_sb=1.
  - MUL: ad_o_sb=0.
  - FIX_HI: ad_o_sb=stored carry.
  - The adder cout is the 33rd sum bit.
REQ-030 No other arithmetic operators (+, -, *) SHALL appear in the module except the iteration counter increment.

Verification
REQ-031 Unsigned 3 x 5: is_signed=0, a=3, b=5 -> done in cycle 37, hi=0x00000000, lo=0x0000000F.
REQ-032 Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Signed mixed: a=0xFFFFFFFF (-1), b=7, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9.
REQ-034 Signed corner: a=b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000.
REQ-035 Handshake: pulse start at cycle 5 of an operation with different operands -> ignored; original result delivered in cycle 37. A start held in the done cycle -> busy=1 next cycle, second result correct.
REQ-036 Reset mid-op: rst at cycle 10 of a multiply -> busy=0, done=0, hi=lo=0 next cycle; no done pulse. A new unsigned 0x80000000 x 2 then gives hi=1, lo=0.
